// File: rtl/dti_channel_monitor.sv
// Passive monitor for N_CH data/valid/ready channels: per-channel handshake
// tracking, saturating transfer/stall counters and sticky protocol errors.
module dti_channel_monitor #(
  parameter int unsigned W           = 16,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STALL_LIMIT = 256,
  localparam int unsigned SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [N_CH*W-1:0]  ch_data,
  input  logic [N_CH-1:0]    ch_valid,
  input  logic [N_CH-1:0]    ch_ready,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_xfer_cnt,
  output logic [CNT_W-1:0]   rd_stall_cnt,
  output logic [2:0]         rd_err,
  output logic [N_CH-1:0]    err_any,
  output logic               irq
);

  localparam int unsigned RUN_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);

  // Error bit positions
  localparam int unsigned E_DROP = 0;
  localparam int unsigned E_DCHG = 1;
  localparam int unsigned E_TOUT = 2;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_e;

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [W-1:0]     hold_q  [N_CH];
  logic [W-1:0]     hold_d  [N_CH];
  logic [RUN_W-1:0] run_q   [N_CH];
  logic [RUN_W-1:0] run_d   [N_CH];
  logic [CNT_W-1:0] xfer_q  [N_CH];
  logic [CNT_W-1:0] xfer_d  [N_CH];
  logic [CNT_W-1:0] stall_q [N_CH];
  logic [CNT_W-1:0] stall_d [N_CH];
  logic [2:0]       err_q   [N_CH];
  logic [2:0]       err_d   [N_CH];
  logic [N_CH-1:0]  err_any_q;
  logic [N_CH-1:0]  err_any_d;
  logic             irq_q;
  logic             irq_d;

  // State register for all channel FSMs, counters, errors and irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= S_IDLE;
        hold_q[i]  <= '0;
        run_q[i]   <= '0;
        xfer_q[i]  <= '0;
        stall_q[i] <= '0;
        err_q[i]   <= '0;
      end
      err_any_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        run_q[i]   <= run_d[i];
        xfer_q[i]  <= xfer_d[i];
        stall_q[i] <= stall_d[i];
        err_q[i]   <= err_d[i];
      end
      err_any_q <= err_any_d;
      irq_q     <= irq_d;
    end
  end

  // Next-state logic: per-channel IDLE/PENDING handshake tracking
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      run_d[i]   = run_q[i];
      xfer_d[i]  = xfer_q[i];
      stall_d[i] = stall_q[i];
      err_d[i]   = err_q[i];
      irq_d      = irq_d | (|err_q[i]);
    end

    if (clear) begin
      // Clear discards any event sampled in the same cycle
      irq_d = 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        state_d[i] = S_IDLE;
        run_d[i]   = '0;
        xfer_d[i]  = '0;
        stall_d[i] = '0;
        err_d[i]   = '0;
      end
    end else if (!enable) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_d[i] = S_IDLE;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        unique case (state_q[i])
          S_IDLE: begin
            if (ch_valid[i]) begin
              if (ch_ready[i]) begin
                if (xfer_q[i] != CNT_MAX) xfer_d[i] = xfer_q[i] + CNT_W'(1);
              end else begin
                if (stall_q[i] != CNT_MAX) stall_d[i] = stall_q[i] + CNT_W'(1);
                hold_d[i]  = ch_data[i*W +: W];
                run_d[i]   = RUN_W'(1);
                state_d[i] = S_PENDING;
                if (STALL_LIMIT == 1) err_d[i][E_TOUT] = 1'b1;
              end
            end
          end
          S_PENDING: begin
            if (!ch_valid[i]) begin
              err_d[i][E_DROP] = 1'b1;
              state_d[i]       = S_IDLE;
            end else begin
              if (ch_data[i*W +: W] != hold_q[i]) begin
                err_d[i][E_DCHG] = 1'b1;
                hold_d[i]        = ch_data[i*W +: W];
              end
              if (ch_ready[i]) begin
                if (xfer_q[i] != CNT_MAX) xfer_d[i] = xfer_q[i] + CNT_W'(1);
                state_d[i] = S_IDLE;
              end else begin
                if (stall_q[i] != CNT_MAX) stall_d[i] = stall_q[i] + CNT_W'(1);
                // Saturating run length makes the timeout fire once per episode
                if (STALL_LIMIT != 0 && run_q[i] != RUN_MAX) begin
                  run_d[i] = run_q[i] + RUN_W'(1);
                  if (run_d[i] == RUN_MAX) err_d[i][E_TOUT] = 1'b1;
                end
              end
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end

    for (int i = 0; i < int'(N_CH); i++) begin
      err_any_d[i] = |err_d[i];
    end
  end

  // Zero-latency read port over registered state
  always_comb begin
    rd_xfer_cnt  = '0;
    rd_stall_cnt = '0;
    rd_err       = '0;
    if ({1'b0, rd_sel} < N_CH_EXT) begin
      rd_xfer_cnt  = xfer_q[rd_sel];
      rd_stall_cnt = stall_q[rd_sel];
      rd_err       = err_q[rd_sel];
    end
  end

  assign err_any = err_any_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_dti_channel_monitor.sv
// Directed bench for dti_channel_monitor: one 4-channel instance with 8-bit
// counters and STALL_LIMIT=4, one 3-channel instance with timeout disabled.
module tb_dti_channel_monitor;

  logic clk = 1'b0;
  logic rst_n, enable, clear;

  logic [63:0] ch_data_a;
  logic [3:0]  ch_valid_a, ch_ready_a;
  logic [1:0]  rd_sel_a;
  logic [7:0]  rd_xfer_a, rd_stall_a;
  logic [2:0]  rd_err_a;
  logic [3:0]  err_any_a;
  logic        irq_a;

  logic [23:0] ch_data_b;
  logic [2:0]  ch_valid_b, ch_ready_b;
  logic [1:0]  rd_sel_b;
  logic [15:0] rd_xfer_b, rd_stall_b;
  logic [2:0]  rd_err_b;
  logic [2:0]  err_any_b;
  logic        irq_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dti_channel_monitor #(.W(16), .N_CH(4), .CNT_W(8), .STALL_LIMIT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .ch_data(ch_data_a), .ch_valid(ch_valid_a), .ch_ready(ch_ready_a),
    .rd_sel(rd_sel_a), .rd_xfer_cnt(rd_xfer_a), .rd_stall_cnt(rd_stall_a),
    .rd_err(rd_err_a), .err_any(err_any_a), .irq(irq_a)
  );

  dti_channel_monitor #(.W(8), .N_CH(3), .CNT_W(16), .STALL_LIMIT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .ch_data(ch_data_b), .ch_valid(ch_valid_b), .ch_ready(ch_ready_b),
    .rd_sel(rd_sel_b), .rd_xfer_cnt(rd_xfer_b), .rd_stall_cnt(rd_stall_b),
    .rd_err(rd_err_b), .err_any(err_any_b), .irq(irq_b)
  );

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int ch, input logic v, input logic r, input logic [15:0] d);
    ch_valid_a[ch]       = v;
    ch_ready_a[ch]       = r;
    ch_data_a[ch*16 +: 16] = d;
  endtask

  task automatic read_a(input string tag, input int sel,
                        input logic [7:0] xfer, input logic [7:0] stall, input logic [2:0] err);
    rd_sel_a = 2'(sel);
    #1;
    check({tag, ".xfer"},  64'(rd_xfer_a),  64'(xfer));
    check({tag, ".stall"}, 64'(rd_stall_a), 64'(stall));
    check({tag, ".err"},   64'(rd_err_a),   64'(err));
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    clear      = 1'b0;
    ch_data_a  = '0;
    ch_valid_a = '0;
    ch_ready_a = '0;
    rd_sel_a   = '0;
    ch_data_b  = '0;
    ch_valid_b = '0;
    ch_ready_b = '0;
    rd_sel_b   = '0;

    // Reset state
    step(2);
    read_a("reset", 0, 8'd0, 8'd0, 3'b000);
    check("reset.err_any", 64'(err_any_a), 64'h0);
    check("reset.irq", 64'(irq_a), 64'h0);
    rst_n = 1'b1;

    // Back-to-back transfers on ch0
    for (int i = 0; i < 10; i++) begin
      drive_a(0, 1'b1, 1'b1, 16'(i + 1));
      step(1);
    end
    drive_a(0, 1'b0, 1'b0, 16'h0);
    read_a("b2b", 0, 8'd10, 8'd0, 3'b000);
    check("b2b.irq", 64'(irq_a), 64'h0);

    // Stall three cycles then accept on ch1
    drive_a(1, 1'b1, 1'b0, 16'hAAAA);
    step(3);
    read_a("stall3", 1, 8'd0, 8'd3, 3'b000);
    drive_a(1, 1'b1, 1'b1, 16'hAAAA);
    step(1);
    drive_a(1, 1'b0, 1'b0, 16'h0);
    read_a("accept", 1, 8'd1, 8'd3, 3'b000);

    // valid drop on ch2 after two stalls; irq trails err_any by a cycle
    drive_a(2, 1'b1, 1'b0, 16'h1234);
    step(2);
    drive_a(2, 1'b0, 1'b0, 16'h0);
    step(1);
    read_a("vdrop", 2, 8'd0, 8'd2, 3'b001);
    check("vdrop.err_any", 64'(err_any_a), 64'h4);
    check("vdrop.irq_early", 64'(irq_a), 64'h0);
    step(1);
    check("vdrop.irq_late", 64'(irq_a), 64'h1);

    // Clear coincident with a ch0 handshake discards the handshake
    clear = 1'b1;
    drive_a(0, 1'b1, 1'b1, 16'h7777);
    step(1);
    clear = 1'b0;
    drive_a(0, 1'b0, 1'b0, 16'h0);
    read_a("clr_ch0", 0, 8'd0, 8'd0, 3'b000);
    read_a("clr_ch2", 2, 8'd0, 8'd0, 3'b000);
    check("clr.err_any", 64'(err_any_a), 64'h0);
    check("clr.irq", 64'(irq_a), 64'h0);

    // Data change while stalled on ch2
    drive_a(2, 1'b1, 1'b0, 16'h0001);
    step(1);
    drive_a(2, 1'b1, 1'b0, 16'h0002);
    step(1);
    drive_a(2, 1'b1, 1'b1, 16'h0002);
    step(1);
    drive_a(2, 1'b0, 1'b0, 16'h0);
    read_a("dchg", 2, 8'd1, 8'd2, 3'b010);
    check("dchg.err_any", 64'(err_any_a), 64'h4);

    // Timeout on ch3 at the fourth stall edge
    drive_a(3, 1'b1, 1'b0, 16'h5555);
    step(3);
    read_a("tout3", 3, 8'd0, 8'd3, 3'b000);
    step(1);
    read_a("tout4", 3, 8'd0, 8'd4, 3'b100);
    step(2);
    read_a("tout6", 3, 8'd0, 8'd6, 3'b100);
    drive_a(3, 1'b1, 1'b1, 16'h5555);
    step(1);
    drive_a(3, 1'b0, 1'b0, 16'h0);
    read_a("tout_done", 3, 8'd1, 8'd6, 3'b100);
    check("tout.err_any", 64'(err_any_a), 64'hC);

    // enable=0 freezes counters and suppresses the valid drop
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    drive_a(1, 1'b1, 1'b0, 16'hBEEF);
    step(2);
    read_a("en_pre", 1, 8'd0, 8'd2, 3'b000);
    enable = 1'b0;
    step(3);
    drive_a(1, 1'b0, 1'b0, 16'h0);
    step(1);
    read_a("en_off", 1, 8'd0, 8'd2, 3'b000);
    enable = 1'b1;
    drive_a(1, 1'b1, 1'b0, 16'hBEEF);
    step(1);
    drive_a(1, 1'b1, 1'b1, 16'hBEEF);
    step(1);
    drive_a(1, 1'b0, 1'b0, 16'h0);
    read_a("en_on", 1, 8'd1, 8'd3, 3'b000);
    check("en.err_any", 64'(err_any_a), 64'h0);

    // Reset pulse mid-PENDING on ch0
    drive_a(0, 1'b1, 1'b0, 16'h4242);
    step(2);
    read_a("rst_pre", 0, 8'd0, 8'd2, 3'b000);
    rst_n = 1'b0;
    drive_a(0, 1'b0, 1'b0, 16'h0);
    #2;
    read_a("rst_mid", 0, 8'd0, 8'd0, 3'b000);
    read_a("rst_ch1", 1, 8'd0, 8'd0, 3'b000);
    check("rst_mid.irq", 64'(irq_a), 64'h0);
    rst_n = 1'b1;
    step(1);
    read_a("rst_post", 0, 8'd0, 8'd0, 3'b000);
    check("rst_post.err_any", 64'(err_any_a), 64'h0);

    // Counter saturation at 8 bits
    drive_a(0, 1'b1, 1'b1, 16'h0);
    for (int i = 0; i < 300; i++) begin
      ch_data_a[15:0] = 16'(i);
      step(1);
    end
    drive_a(0, 1'b0, 1'b0, 16'h0);
    read_a("sat", 0, 8'd255, 8'd0, 3'b000);

    // Instance B: long stall with timeout disabled, then out-of-range select
    ch_valid_b[2]      = 1'b1;
    ch_data_b[23:16]   = 8'h3C;
    ch_valid_b[0]      = 1'b1;
    ch_ready_b[0]      = 1'b1;
    step(10);
    ch_valid_b = '0;
    ch_ready_b = '0;
    rd_sel_b = 2'd2;
    #1;
    check("b_ch2.stall", 64'(rd_stall_b), 64'd10);
    check("b_ch2.err", 64'(rd_err_b), 64'h0);
    rd_sel_b = 2'd0;
    #1;
    check("b_ch0.xfer", 64'(rd_xfer_b), 64'd10);
    rd_sel_b = 2'd3;
    #1;
    check("b_oob.xfer", 64'(rd_xfer_b), 64'h0);
    check("b_oob.stall", 64'(rd_stall_b), 64'h0);
    check("b_oob.err", 64'(rd_err_b), 64'h0);
    check("b.irq", 64'(irq_b), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
